pixel_write_bridge: RTL

Sits directly downstream of the board painter, between its pixel-write outputs and the VGA adapter frame-buffer write port. The painter holds print_enable high for several cycles per pixel. This block converts each rising edge of print_enable into exactly one buffered write entry {x, y, colour}. It drains the entries to the VGA adapter as single-cycle plot pulses, gated by the adapter's ready signal, and flags any pixel lost to overflow.

---
 rtl/pixel_write_bridge.sv | 118 +++++++++++
 1 files changed

// File: rtl/pixel_write_bridge.sv
// Turns each rising edge of the painter's print_enable into one queued {x, y, colour}
// entry and drains the queue to the VGA adapter as single-cycle plot pulses.
// Optional coordinate clipping is enabled by defining PIXEL_BRIDGE_CLIP_EN.
//
// DRAIN machine:
//   state  | meaning
//   IDLE   | queue empty, nothing to plot
//   ACTIVE | at least one entry queued, pops whenever vga_ready is high
module pixel_write_bridge #(
   parameter int X_BITS     = 8,
   parameter int Y_BITS     = 7,
   parameter int COLOR_BITS = 3,
   parameter int DEPTH      = 8,
   parameter int SCR_W      = 160,
   parameter int SCR_H      = 120
) (
   input  logic                     Clck,
   input  logic                     Reset,
   input  logic [X_BITS-1:0]        paint_x_co,
   input  logic [Y_BITS-1:0]        paint_y_co,
   input  logic [COLOR_BITS-1:0]    color,
   input  logic                     print_enable,
   input  logic                     vga_ready,
   input  logic                     clr_overflow,
   output logic [X_BITS-1:0]        vga_x,
   output logic [Y_BITS-1:0]        vga_y,
   output logic [COLOR_BITS-1:0]    vga_colour,
   output logic                     vga_plot,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     overflow
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int E_BITS   = X_BITS + Y_BITS + COLOR_BITS;

`ifdef PIXEL_BRIDGE_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} drain_t;

   drain_t                state, state_next;
   logic                  pe_d;
   logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
   logic [PTR_BITS:0]     fill_next;
   logic [E_BITS-1:0]     mem [DEPTH];
   logic [E_BITS-1:0]     head;
   logic                  in_range, push, pop, full, accept, drop, draining;

   assign in_range = (int'(paint_x_co) < SCR_W) && (int'(paint_y_co) < SCR_H);
   assign push     = print_enable & ~pe_d & (~CLIP_EN | in_range);
   assign pop      = draining & vga_ready;
   assign full     = (fill == (PTR_BITS+1)'(DEPTH));
   // A full queue still takes a new pixel when the same cycle frees a slot.
   assign accept   = push & (~full | pop);
   assign drop     = push & full & ~pop;
   assign head     = mem[rd_ptr];

   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ACTIVE;
         ACTIVE:  if (pop && (fill == (PTR_BITS+1)'(1)) && !accept) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      draining = (state == ACTIVE);
      busy     = (state == ACTIVE) | vga_plot;
   end

   always_comb begin
      case ({accept, pop})
         2'b10:   fill_next = fill + (PTR_BITS+1)'(1);
         2'b01:   fill_next = fill - (PTR_BITS+1)'(1);
         default: fill_next = fill;
      endcase
   end

   always_ff @(posedge Clck) begin
      if (accept) mem[wr_ptr] <= {paint_x_co, paint_y_co, color};
   end

   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         pe_d       <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill       <= '0;
         overflow   <= 1'b0;
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
      end else begin
         pe_d <= print_enable;
         fill <= fill_next;
         if (accept) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop) begin
            rd_ptr                     <= rd_ptr + PTR_BITS'(1);
            {vga_x, vga_y, vga_colour} <= head;
         end
         vga_plot <= pop;
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule
